// File: rtl/hci_core_sink_lite_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hci_core_intf / hwpe_stream_intf_stream : store-side memory port and
// incoming data stream used by hci_core_sink_lite.       Rev 1.0
// ----------------------------------------------------------------------------
interface hci_core_intf #(
  parameter int DW  = 64,
  parameter int UW  = 1,
  parameter int IW  = 1,
  parameter int EW  = 1,
  parameter int EHW = 0
);
  localparam int EHW_W = (EHW > 0) ? EHW : 1;

  logic             req;
  logic             gnt;
  logic [31:0]      add;
  logic             wen;
  logic [DW-1:0]    data;
  logic [DW/8-1:0]  be;
  logic [UW-1:0]    user;
  logic [IW-1:0]    id;
  logic [EW-1:0]    ecc;
  logic [EHW_W-1:0] ereq;
  logic             r_ready;
  logic [EHW_W-1:0] r_eready;
  logic             r_valid;

  modport initiator (
    output req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
    input  gnt, r_valid
  );
  modport target (
    input  req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
    output gnt, r_valid
  );
endinterface

interface hwpe_stream_intf_stream #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface
`default_nettype wire

// File: rtl/hci_core_sink_lite.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hci_core_sink_lite : writes a strided sequence of stream beats to memory,
// with optional byte-offset stores and a bound on pending responses. Rev 1.0
// ----------------------------------------------------------------------------
module hci_core_sink_lite #(
  parameter int TRANS_CNT           = 16,
  parameter int MISALIGNED_ACCESSES = 1,
  parameter int MAX_OUTSTANDING     = 8,
  parameter int STREAM_DW           = 32,
  parameter int EHW                 = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  hci_core_intf.initiator      tcdm,
  hwpe_stream_intf_stream.sink stream,
  input  logic                 req_start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [TRANS_CNT-1:0] tot_len_i,
  output logic                 ready_start_o,
  output logic                 done_o,
  output logic [TRANS_CNT-1:0] cnt_o
);

  localparam int DW    = (MISALIGNED_ACCESSES != 0) ? STREAM_DW + 32 : STREAM_DW;
  localparam int BW    = DW / 8;
  localparam int EHW_W = (EHW > 0) ? EHW : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WORKING = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e               state_q;
  logic [31:0]          addr_q;
  logic [31:0]          stride_q;
  logic [TRANS_CNT-1:0] len_q;
  logic [TRANS_CNT-1:0] cnt_q;
  logic [3:0]           outst_q;

  logic          below_max;
  logic          req;
  logic          hs;
  logic          rsp;
  logic          done;
  logic [DW-1:0] wdata;
  logic [BW-1:0] wbe;

  assign below_max = outst_q < 4'(MAX_OUTSTANDING);
  assign req       = enable_i & (state_q == WORKING) & stream.valid & below_max;
  assign hs        = req & tcdm.gnt;
  // Responses with nothing pending are dropped so the counter cannot wrap.
  assign rsp       = enable_i & tcdm.r_valid & (outst_q != 4'd0);
  assign done      = enable_i & ~clear_i & (state_q == DONE) & (outst_q == 4'd0);

  generate
    if (MISALIGNED_ACCESSES != 0) begin : g_misaligned
      logic [1:0] off;
      assign off   = addr_q[1:0];
      assign wdata = {32'b0, stream.data} << {off, 3'b000};
      assign wbe   = {4'b0, stream.strb} << off;
    end else begin : g_aligned
      assign wdata = stream.data;
      assign wbe   = stream.strb;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
    end else if (enable_i) begin
      if (hs && !rsp) begin
        outst_q <= outst_q + 4'd1;
      end else if (!hs && rsp) begin
        outst_q <= outst_q - 4'd1;
      end
      case (state_q)
        IDLE: begin
          if (req_start_i) begin
            addr_q   <= base_addr_i;
            stride_q <= stride_i;
            len_q    <= tot_len_i;
            state_q  <= (tot_len_i == '0) ? DONE : WORKING;
          end
        end
        WORKING: begin
          if (hs) begin
            addr_q <= addr_q + stride_q;
            cnt_q  <= cnt_q + TRANS_CNT'(1);
            if (cnt_q == len_q - TRANS_CNT'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (outst_q == 4'd0) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tcdm.req     = req;
  assign tcdm.wen     = 1'b0;
  assign tcdm.add     = (enable_i && state_q == WORKING) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign tcdm.data    = wdata;
  assign tcdm.be      = wbe;
  assign tcdm.user    = '0;
  assign tcdm.id      = '0;
  assign tcdm.ecc     = '0;
  assign tcdm.r_ready = 1'b1;

  generate
    if (EHW > 0) begin : g_ecc
      assign tcdm.ereq     = {EHW_W{req}};
      assign tcdm.r_eready = {EHW_W{1'b1}};
    end else begin : g_no_ecc
      assign tcdm.ereq     = '0;
      assign tcdm.r_eready = '1;
    end
  endgenerate

  assign stream.ready  = hs;
  assign ready_start_o = (state_q == IDLE);
  assign done_o        = done;
  assign cnt_o         = cnt_q;

endmodule
`default_nettype wire

// File: doc/hci_core_sink_lite.md
HCI_CORE_SINK_LITE -- requirements
Module: hci_core_sink_lite

Interface
REQ-001 SHALL have parameter TRANS_CNT, default 16: width of the transaction counter and tot_len.
REQ-002 SHALL have parameter MISALIGNED_ACCESSES, default 1: 1 enables byte-offset stores; 0 requires word-aligned addresses.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8: maximum granted writes whose response is still pending (at least 1, at most 15).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state samples on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port clear_i, input, 1 bit: synchronous soft clear.
REQ-007 SHALL have port enable_i, input, 1 bit: global enable; when low, all state holds.
REQ-008 SHALL have port tcdm, hci_core_intf.initiator, width DW: store-side memory port; DW = stream width + 32 when MISALIGNED_ACCESSES=1, otherwise equal to the stream width.
REQ-009 SHALL have port stream, hwpe_stream_intf_stream.sink, width DW-32 (or DW): incoming data and strobes.
REQ-010 SHALL have port req_start_i, input, 1 bit: start request; sampled only in IDLE.
REQ-011 SHALL have port base_addr_i, input, 32 bits: byte address of the first store.
REQ-012 SHALL have port stride_i, input, 32 bits: byte increment applied per store.
REQ-013 SHALL have port tot_len_i, input, TRANS_CNT bits: number of stores to issue.
REQ-014 SHALL have port ready_start_o, output, 1 bit: high while in IDLE.
REQ-015 SHALL have port done_o, output, 1 bit: one-cycle pulse at completion.
REQ-016 SHALL have port cnt_o, output, TRANS_CNT bits: number of stores granted so far.

Function
REQ-017 SHALL implement an FSM with three states: IDLE, WORKING, DONE.
REQ-018 IDLE: on req_start_i, SHALL register base_addr_i, stride_i and tot_len_i, then go to WORKING; if tot_len_i=0, SHALL go to DONE instead.
REQ-019 WORKING: tcdm.req SHALL equal stream.valid, provided outstanding < MAX_OUTSTANDING; tcdm.wen=0; stream.ready = tcdm.req & tcdm.gnt.
REQ-020 tcdm.add SHALL be {addr_q[31:2],2'b00}; tcdm.user, tcdm.id and tcdm.ecc SHALL be 0.
REQ-021 With MISALIGNED_ACCESSES=1, and off = addr_q[1:0]: tcdm.data = stream.data shifted left by 8*off; tcdm.be = stream.strb shifted left by off; unused bytes are 0.
REQ-022 With MISALIGNED_ACCESSES=0: tcdm.data = stream.data and tcdm.be = stream.strb; addr_q[1:0] SHALL be ignored.
REQ-023 On each req&gnt: addr_q += stride_i modulo 2^32 (wraps without error); cnt_o increments by 1.
REQ-024 A req&gnt occurring when cnt_o = tot_len-1 SHALL move the FSM to DONE in the same edge.
REQ-025 The outstanding counter SHALL: +1 on req&gnt; -1 on r_valid; stay unchanged when both occur in the same cycle.
REQ-026 tcdm.r_ready SHALL be constant 1.
REQ-027 When outstanding = MAX_OUTSTANDING, tcdm.req SHALL be 0 and stream.ready SHALL be 0.
REQ-028 DONE: tcdm.req SHALL be 0; when outstanding = 0, done_o SHALL be 1 for that cycle, cnt_o SHALL clear, and the FSM SHALL go to IDLE.
REQ-029 Outside WORKING, and whenever enable_i=0: tcdm.req=0, stream.ready=0, tcdm.add=0.
REQ-030 A req_start_i outside IDLE SHALL be ignored.
REQ-031 An r_valid arriving with outstanding=0 SHALL be ignored, and the counter SHALL not underflow.
REQ-032 clear_i SHALL, on the next edge and regardless of enable_i: set FSM to IDLE and zero addr_q, cnt_o and outstanding; done_o SHALL not pulse.
REQ-033 ECC handshake: when EHW>0, tcdm.ereq SHALL replicate tcdm.req and tcdm.r_eready SHALL replicate tcdm.r_ready; otherwise tcdm.ereq=0 and tcdm.r_eready=all ones.

Reset
REQ-034 While rst_i=1, SHALL hold: FSM=IDLE, addr_q=0, cnt_o=0, outstanding=0.
REQ-035 During reset, SHALL drive ready_start_o=1, done_o=0, tcdm.req=0, stream.ready=0.
REQ-036 Assertion of rst_i mid-operation SHALL abort immediately; responses arriving after reset release SHALL be ignored per REQ-031.

Verification
REQ-037 Aligned burst: base=0x100, stride=4, len=4, gnt=1, r_valid one cycle after each grant -> adds 0x100, 0x104, 0x108, 0x10C; be=0x0F each; done_o pulses once; cnt_o returns to 0.
REQ-038 Misaligned store: base=0x203, strobe=0xF, data=0xAABBCCDD -> add=0x200, be=0x78, data=0x00AABBCCDD000000.
REQ-039 Backpressure: MAX_OUTSTANDING=2, r_valid withheld, len=4 -> req drops after 2 grants; it resumes one cycle after the first r_valid.
REQ-040 Zero length: req_start with len=0 -> no tcdm.req; done_o one cycle later; FSM returns to IDLE.
REQ-041 Wrap and simultaneous events: base=0xFFFFFFFC, stride=4 -> second add=0x00000000; gnt and r_valid in the same cycle -> outstanding unchanged.
REQ-042 Abort: rst_i or clear_i pulsed after 2 of 6 grants -> IDLE next cycle; no done_o pulse; a new start then completes normally.
